// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Per-register pending-write scoreboard with RAW/WAW/capacity
//                stall generation and an ecall drain/service sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_validD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic        EcallD,
    input  logic        flushD,
    input  logic        wb_validW,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    input  logic        ecall_done,
    output logic        stallD,
    output logic        issue_fireD,
    output logic        ecall_go,
    output logic [31:0] pending_mask,
    output logic [3:0]  inflight
);

    localparam logic [3:0] C_MAX_INF = 4'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // Two bits per register; slot 0 is never written so x0 always reads 0.
    logic [63:0] cnt_q, cnt_d;
    logic [3:0]  inflight_q, inflight_d;

    logic w_ret_wr, w_src1_haz, w_src2_haz, w_waw_haz, w_cap_haz, w_haz;
    logic w_stall, w_fire;

    function automatic logic [1:0] cnt_of(input logic [63:0] v, input logic [4:0] r);
        return v[{r, 1'b0} +: 2];
    endfunction

    // A retiring write to the same register bypasses through the register file.
    function automatic logic src_haz(input logic [63:0] v, input logic [4:0] rs,
                                     input logic ret_wr, input logic [4:0] rdw);
        logic [1:0] c;
        c = cnt_of(v, rs);
        return (rs != 5'd0) &&
               ((c >= 2'd2) || ((c == 2'd1) && !(ret_wr && (rdw == rs))));
    endfunction

    always_comb begin
        w_ret_wr   = wb_validW & RegWriteW & (RdW != 5'd0);
        w_src1_haz = src_haz(cnt_q, Rs1D, w_ret_wr, RdW);
        w_src2_haz = src_haz(cnt_q, Rs2D, w_ret_wr, RdW);
        w_waw_haz  = RegWriteD & (RdD != 5'd0) & (cnt_of(cnt_q, RdD) == 2'd3);
        w_cap_haz  = (inflight_q == C_MAX_INF) & ~wb_validW;
        w_haz      = w_src1_haz | w_src2_haz | w_waw_haz | w_cap_haz;
        w_stall    = issue_validD & (w_haz
                                   | (state_q == DRAIN)
                                   | ((state_q == SERVICE) & ~ecall_done)
                                   | ((state_q == IDLE) & EcallD));
        w_fire     = issue_validD & ~w_stall & (~flushD | (state_q == SERVICE));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_validD & EcallD & ~flushD) state_d = DRAIN;
            DRAIN: begin
                if (flushD)                                     state_d = IDLE;
                else if ((inflight_q == 4'd0) && !wb_validW)    state_d = SERVICE;
            end
            SERVICE: if (ecall_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic inc, dec;
        logic [1:0] c;
        cnt_d = cnt_q;
        for (int r = 1; r < 32; r++) begin
            inc = w_fire & RegWriteD & (RdD == 5'(r));
            dec = w_ret_wr & (RdW == 5'(r));
            c   = cnt_q[2*r +: 2];
            if (inc && !dec && (c != 2'd3))
                cnt_d[2*r +: 2] = c + 2'd1;
            else if (dec && !inc && (c != 2'd0))
                cnt_d[2*r +: 2] = c - 2'd1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (w_fire && !wb_validW && (inflight_q != 4'hF))
            inflight_d = inflight_q + 4'd1;
        else if (wb_validW && !w_fire && (inflight_q != 4'd0))
            inflight_d = inflight_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inflight_q <= '0;
        end else begin
            assert (!(wb_validW && (inflight_q == 4'd0)));
            assert (!(w_ret_wr && (cnt_of(cnt_q, RdW) == 2'd0)));
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 1; r < 32; r++)
            pending_mask[r] = |cnt_q[2*r +: 2];
    end

    assign stallD      = w_stall;
    assign issue_fireD = w_fire;
    assign ecall_go    = (state_q == SERVICE);
    assign inflight    = inflight_q;

endmodule
`default_nettype wire
